// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I core and its memory-port arbiter.
package riscv_pkg;

  localparam int XLEN = 32;

  // Arbiter FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_IFETCH = 2'd2;

  // All-zero instruction word, decoded by the core as a pipeline bubble
  localparam logic [31:0] INSN_NOP = 32'h0;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between instruction fetch and data access.
// Data wins over fetch, one transaction at a time, with a single-entry fetch
// buffer and a timeout that turns a dead bus into a completed zero access.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int XLEN    = riscv_pkg::XLEN
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic [XLEN-1:0] I_imem_addr,
  output logic [XLEN-1:0] O_imem_data,
  input  logic [XLEN-1:0] I_dmem_addr,
  input  logic [XLEN-1:0] I_dmem_wdata,
  input  logic [3:0]      I_dmem_wmask,
  input  logic            I_dmem_rd,
  input  logic            I_dmem_we,
  output logic [XLEN-1:0] O_dmem_rdata,
  output logic            O_stall,
  output logic            O_mem_req,
  output logic            O_mem_we,
  output logic [XLEN-1:0] O_mem_addr,
  output logic [XLEN-1:0] O_mem_wdata,
  output logic [3:0]      O_mem_wmask,
  input  logic            I_mem_ack,
  input  logic [XLEN-1:0] I_mem_rdata,
  output logic            O_bus_err
);

  // Counter only needs to reach TIMEOUT-1; the abort fires on the edge that
  // would take it to TIMEOUT, so req is held for exactly TIMEOUT cycles.
  localparam int TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [1:0]      state;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_tag;
  logic            data_done;
  logic [TW-1:0]   tcnt;

  logic            fetch_hit;
  logic            data_pend;
  logic            timeout_hit;
  logic            finish;
  logic [XLEN-1:0] rsp_data;

  assign fetch_hit   = fetch_valid && (fetch_tag == I_imem_addr);
  assign data_pend   = (I_dmem_rd || I_dmem_we) && !data_done;
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TLIM));
  assign finish      = I_mem_ack || timeout_hit;
  // A timed-out access completes with zero data (a bubble for fetches)
  assign rsp_data    = I_mem_ack ? I_mem_rdata : XLEN'(INSN_NOP);

  // Freeze the core until its fetch hits and its data access has completed
  always_comb O_stall = !I_rst && (!fetch_hit || data_pend);

  // Arbitration FSM, fetch buffer, data completion and timeout counter
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state        <= ST_IDLE;
      O_mem_req    <= 1'b0;
      O_mem_we     <= 1'b0;
      O_mem_addr   <= '0;
      O_mem_wdata  <= '0;
      O_mem_wmask  <= '0;
      O_imem_data  <= XLEN'(INSN_NOP);
      O_dmem_rdata <= '0;
      O_bus_err    <= 1'b0;
      fetch_valid  <= 1'b0;
      fetch_tag    <= '0;
      data_done    <= 1'b0;
      tcnt         <= '0;
    end else begin
      // Core advances on this edge: the next data access is a new one
      if (!O_stall) data_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (data_pend) begin
            state       <= ST_DATA;
            O_mem_req   <= 1'b1;
            O_mem_we    <= I_dmem_we;
            O_mem_addr  <= I_dmem_addr;
            O_mem_wdata <= I_dmem_wdata;
            O_mem_wmask <= I_dmem_wmask;
          end else if (!fetch_hit) begin
            state       <= ST_IFETCH;
            O_mem_req   <= 1'b1;
            O_mem_we    <= 1'b0;
            O_mem_addr  <= I_imem_addr;
            O_mem_wmask <= '0;
            fetch_tag   <= I_imem_addr;
            // Old contents no longer belong to the tag being fetched
            fetch_valid <= 1'b0;
          end
        end
        ST_DATA, ST_IFETCH: begin
          tcnt <= tcnt + 1'b1;
          if (finish) begin
            state     <= ST_IDLE;
            O_mem_req <= 1'b0;
            if (!I_mem_ack) O_bus_err <= 1'b1;
            if (state == ST_DATA) begin
              data_done <= 1'b1;
              if (!O_mem_we) O_dmem_rdata <= rsp_data;
            end else begin
              fetch_valid <= 1'b1;
              O_imem_data <= rsp_data;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and random core accesses against a memory/buffer reference model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0, imem_data;
  logic [31:0] dmem_addr = '0, dmem_wdata = '0, dmem_rdata;
  logic [3:0]  dmem_wmask = '0;
  logic        dmem_rd = 1'b0, dmem_we = 1'b0;
  logic        stall, mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO), .XLEN(32)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_imem_addr(imem_addr), .O_imem_data(imem_data),
    .I_dmem_addr(dmem_addr), .I_dmem_wdata(dmem_wdata), .I_dmem_wmask(dmem_wmask),
    .I_dmem_rd(dmem_rd), .I_dmem_we(dmem_we), .O_dmem_rdata(dmem_rdata),
    .O_stall(stall), .O_mem_req(mem_req), .O_mem_we(mem_we),
    .O_mem_addr(mem_addr), .O_mem_wdata(mem_wdata), .O_mem_wmask(mem_wmask),
    .I_mem_ack(mem_ack), .I_mem_rdata(mem_rdata), .O_bus_err(bus_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bus-side memory (what the responder serves) and the model's own view
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0001_3579;
  endfunction
  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction
  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] v;
    v = ref_rd(a);
    for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    rmem[a] = v;
  endtask
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mem[a] = d; rmem[a] = d;
  endtask

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask; } txn_t;
  txn_t log_q[$];

  // Memory responder: acks after 0..2 idle cycles, or is driven by hand
  bit          man_mode = 0, mem_dead = 0;
  logic        man_ack = 1'b0, rsp_ack = 1'b0;
  logic [31:0] man_rdata = '0, rsp_rdata = '0;
  int          lat_cnt = 0, lat_cur = 0, lat_fixed = -1, req_hi = 0;

  assign mem_ack   = man_mode ? man_ack   : rsp_ack;
  assign mem_rdata = man_mode ? man_rdata : rsp_rdata;

  initial forever begin
    @(negedge clk);
    if (mem_req) req_hi++;
    if (rsp_ack) begin
      rsp_ack = 1'b0;
      lat_cnt = 0;
      lat_cur = (lat_fixed < 0) ? int'($urandom_range(0, 2)) : lat_fixed;
    end else if (!mem_req || man_mode || mem_dead) begin
      lat_cnt = 0;
    end else if (lat_cnt >= lat_cur) begin
      txn_t t;
      logic [31:0] v;
      t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata; t.wmask = mem_wmask;
      log_q.push_back(t);
      rsp_ack = 1'b1;
      if (mem_we) begin
        v = bus_rd(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_wmask[b]) v[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr] = v;
        rsp_rdata = 32'hFFFF_FFFF;
      end else begin
        rsp_rdata = bus_rd(mem_addr);
      end
    end else begin
      lat_cnt++;
    end
  end

  // Present one core access (called just after a posedge) and wait for release
  task automatic step(input logic [31:0] ia, input logic rd, input logic we,
                      input logic [31:0] da, input logic [31:0] wd, input logic [3:0] wm,
                      output bit to);
    int cyc;
    log_q.delete();
    imem_addr = ia; dmem_rd = rd; dmem_we = we;
    dmem_addr = da; dmem_wdata = wd; dmem_wmask = wm;
    cyc = 0;
    @(negedge clk);
    while (stall && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    to = stall;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Fetch addresses live below 0x100, data addresses at or above it
  task automatic check_step(input string tg, input bit to, input int nf_e, input int nd_e,
                            input logic we_e, input logic [31:0] id_e, input logic [31:0] rd_e);
    int nf, nd;
    logic dwe;
    nf = 0; nd = 0; dwe = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].addr < 32'h100) nf++;
      else begin nd++; dwe = log_q[i].we; end
    end
    chk({tg, " stall_release"}, 32'(to), 32'd0);
    chk({tg, " fetch_txns"}, 32'(nf), 32'(nf_e));
    chk({tg, " data_txns"}, 32'(nd), 32'(nd_e));
    chk({tg, " imem_data"}, imem_data, id_e);
    chk({tg, " dmem_rdata"}, dmem_rdata, rd_e);
    if (nd_e > 0 && nd > 0) chk({tg, " data_we"}, 32'(dwe), 32'(we_e));
    if (nd_e > 0 && nf_e > 0 && log_q.size() > 0)
      chk({tg, " data_first"}, 32'(log_q[0].addr >= 32'h100), 32'd1);
  endtask

  typedef struct {
    logic [31:0] ia; logic rd; logic we; logic [31:0] da; logic [31:0] wd; logic [3:0] wm;
    int nf; int nd; logic [31:0] idata; logic [31:0] rdata;
  } vec_t;
  vec_t tbl[6];

  bit          tag_v = 0;
  logic [31:0] last_tag = '0, exp_rdata = '0;

  initial begin
    bit to;
    preload(32'h0,   32'h0050_0093);
    preload(32'h8,   32'h00A0_0113);
    preload(32'h100, 32'hDEAD_BEEF);
    preload(32'h204, 32'h1122_3344);

    tbl[0] = '{32'h0, 1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 1, 0, 32'h0050_0093, 32'h0};
    tbl[1] = '{32'h0, 1'b1, 1'b0, 32'h100, 32'h0,         4'h0, 0, 1, 32'h0050_0093, 32'hDEAD_BEEF};
    tbl[2] = '{32'h8, 1'b0, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 1, 1, 32'h00A0_0113, 32'hDEAD_BEEF};
    tbl[3] = '{32'h8, 1'b1, 1'b0, 32'h200, 32'h0,         4'h0, 0, 1, 32'h00A0_0113, 32'h1234_5678};
    tbl[4] = '{32'h8, 1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 4'h3, 0, 1, 32'h00A0_0113, 32'h1234_5678};
    tbl[5] = '{32'h8, 1'b1, 1'b0, 32'h204, 32'h0,         4'h0, 0, 1, 32'h00A0_0113, 32'h1122_F00D};

    // Reset state, with a fetch address that would otherwise miss
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst imem_data", imem_data, 32'h0);
    chk("rst dmem_rdata", dmem_rdata, 32'h0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    adv();
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].ia, tbl[i].rd, tbl[i].we, tbl[i].da, tbl[i].wd, tbl[i].wm, to);
      check_step($sformatf("vec%0d", i), to, tbl[i].nf, tbl[i].nd, tbl[i].we,
                 tbl[i].idata, tbl[i].rdata);
      if (i == 0 && log_q.size() > 0) begin
        chk("vec0 req_addr", log_q[0].addr, 32'h0);
        chk("vec0 req_we", 32'(log_q[0].we), 32'd0);
      end
      if (tbl[i].we) ref_wr(tbl[i].da, tbl[i].wd, tbl[i].wm);
      adv();
    end
    exp_rdata = 32'h1122_F00D;

    // Fetch redirect while the fetch of 0x8 is outstanding (ack after 3 cycles)
    step(32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, to);
    adv();
    lat_fixed = 2; lat_cur = 2;
    log_q.delete();
    imem_addr = 32'h8; dmem_rd = 1'b0; dmem_we = 1'b0;
    begin
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (!mem_req && cyc < 10) begin @(negedge clk); cyc++; end
      chk("redir req_seen", 32'(mem_req), 32'd1);
      adv();
      imem_addr = 32'h40;
      cyc = 0;
      @(negedge clk);
      while (stall && cyc < 80) begin @(negedge clk); cyc++; end
    end
    chk("redir stall_release", 32'(stall), 32'd0);
    chk("redir txns", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("redir first_addr", log_q[0].addr, 32'h8);
      chk("redir second_addr", log_q[1].addr, 32'h40);
    end
    chk("redir imem_data", imem_data, ref_rd(32'h40));
    chk("redir bus_err", 32'(bus_err), 32'd0);
    adv();
    lat_fixed = -1;
    tag_v = 1; last_tag = 32'h40;

    // Random core accesses against the model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ia, da, wd;
      logic [3:0]  wm;
      int          op, nf_e, nd_e;
      ia = 32'($urandom_range(0, 7)) * 4;
      op = $urandom_range(0, 3);
      da = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      wd = $urandom;
      wm = 4'($urandom_range(1, 15));
      nf_e = (tag_v && last_tag == ia) ? 0 : 1;
      nd_e = (op != 0) ? 1 : 0;
      if (op == 1) exp_rdata = ref_rd(da);
      step(ia, op[0], op[1], da, wd, wm, to);
      check_step($sformatf("rnd%0d", n), to, nf_e, nd_e, op[1], ref_rd(ia), exp_rdata);
      if (op[1]) ref_wr(da, wd, wm);
      tag_v = 1; last_tag = ia;
      adv();
    end

    // Dead bus: fetch then load time out after TO cycles of request
    mem_dead = 1;
    req_hi = 0;
    step(32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, to);
    chk("tmo fetch stall_release", 32'(to), 32'd0);
    chk("tmo fetch req_cycles", 32'(req_hi), 32'(TO));
    chk("tmo fetch bus_err", 32'(bus_err), 32'd1);
    chk("tmo fetch imem_data", imem_data, 32'h0);
    adv();
    step(32'h60, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, to);
    chk("tmo load stall_release", 32'(to), 32'd0);
    chk("tmo load dmem_rdata", dmem_rdata, 32'h0);
    adv();
    mem_dead = 0;
    step(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, to);
    check_step("post_tmo", to, 1, 0, 1'b0, ref_rd(32'h0), 32'h0);
    chk("post_tmo bus_err sticky", 32'(bus_err), 32'd1);
    adv();

    // Reset while a request is outstanding; a late ack must be ignored
    man_mode = 1;
    imem_addr = 32'h70;
    begin
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (!mem_req && cyc < 10) begin @(negedge clk); cyc++; end
      chk("rstmid req_seen", 32'(mem_req), 32'd1);
    end
    adv();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid stall", 32'(stall), 32'd0);
    man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0;
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid req_dropped", 32'(mem_req), 32'd0);
    chk("rstmid imem_data", imem_data, 32'h0);
    adv();
    man_ack = 1'b0;
    @(negedge clk);
    chk("rstmid imem_after_ack", imem_data, 32'h0);
    chk("rstmid dmem_rdata", dmem_rdata, 32'h0);
    chk("rstmid bus_err", 32'(bus_err), 32'd0);
    chk("rstmid refetch_req", 32'(mem_req), 32'd1);
    chk("rstmid refetch_addr", mem_addr, 32'h70);
    chk("rstmid stalled", 32'(stall), 32'd1);
    man_ack = 1'b1; man_rdata = 32'h0070_0093;
    adv();
    man_ack = 1'b0;
    @(negedge clk);
    chk("rstmid refetch_data", imem_data, 32'h0070_0093);
    chk("rstmid refetch_stall", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

endmodule
